ppu_a12_edge_filter: RTL

// - Upstream stage of the scanline-IRQ mappers (MMC3-class, 117, ...): turns raw async PPU A12 into one clean
//   "scanline tick" pulse per qualified rising edge.
// - Mapper IRQ counters then decrement on a12_rise instead of keeping their own M2-sampled A12 shift registers.
// - Rejects sub-M2 glitches and the 8x16-sprite / BG-fetch A12 toggles.
// - Exposes its state to the save-state bus.

---
 rtl/map_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/ppu_a12_edge_filter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// map_pkg: constants shared by the scanline-IRQ mapper front ends.
package map_pkg;

    // A12 edge-detector states
    typedef enum logic [1:0] {
        ST_HIGH  = 2'd0,
        ST_LOW   = 2'd1,
        ST_ARMED = 2'd2
    } a12_state_t;

    // Save-state register offsets from the block's base address
    localparam logic [1:0] SS_OFF_TICK = 2'd0;
    localparam logic [1:0] SS_OFF_STAT = 2'd1;
    localparam logic [1:0] SS_OFF_GCNT = 2'd2;
    localparam logic [1:0] SS_OFF_CFG  = 2'd3;

    // Filter defaults used by every scanline mapper
    localparam int LOW_M2_DEF     = 3;
    localparam int GLITCH_CLK_DEF = 2;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs, with a per-bit reset value.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; the first stage may go metastable, the second settles it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ppu_a12_edge_filter.sv
// ppu_a12_edge_filter: synchronises raw PPU A12 and CPU M2, de-glitches A12, and emits one
// a12_rise pulse per filtered rising edge that follows a low period of at least LOW_M2 M2 falls.
module ppu_a12_edge_filter
    import map_pkg::*;
#(
    parameter int         LOW_M2     = LOW_M2_DEF,
    parameter int         GLITCH_CLK = GLITCH_CLK_DEF,
    parameter logic [7:0] SS_BASE    = 8'd16
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       m2,
    input  logic       ppu_a12,
    input  logic       en,
    output logic       a12_rise,
    output logic       a12_flt,
    output logic       armed,
    output logic [7:0] tick_cnt,
    input  logic       ss_act,
    input  logic       ss_we,
    input  logic [7:0] ss_addr,
    input  logic [7:0] ss_din,
    output logic [7:0] ss_rdat
);

    localparam logic [2:0] LOW_TGT     = 3'(LOW_M2);
    localparam logic [3:0] GLITCH_LAST = 4'(GLITCH_CLK - 1);
    localparam logic [7:0] CFG_WORD    = {4'(LOW_M2), 4'(GLITCH_CLK)};

    logic [1:0] sync_q;
    logic       m2_s;
    logic       a12_s;
    logic       m2_prev;
    logic       m2_fall;
    a12_state_t state;
    logic [2:0] low_cnt;
    logic [2:0] low_next;
    logic [3:0] gcnt;
    logic [7:0] ss_off;
    logic       ss_hit;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk     (clk),
        .rst     (map_rst),
        .rst_val (2'b11),
        .d       ({m2, ppu_a12}),
        .q       (sync_q)
    );

    assign m2_s  = sync_q[1];
    assign a12_s = sync_q[0];

    // Delay synced M2 by one clk to find its falling edge; runs even during a save-state session
    always_ff @(posedge clk or posedge map_rst) begin
        // NOTE: sequential state always uses <=, so every flop samples pre-edge values regardless of statement order.
        if (map_rst) m2_prev <= 1'b1;
        else         m2_prev <= m2_s;
    end

    assign m2_fall = m2_prev & ~m2_s;

    // Post-increment low count, so a rise landing on the arming M2 edge is still qualified
    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational (no latch on paths that skip the if).
        low_next = low_cnt;
        if (m2_fall && (low_cnt < LOW_TGT)) low_next = low_cnt + 3'd1;
    end

    // Offset into this block's save-state window; wraps cleanly if SS_BASE sits near 8'hFF
    assign ss_off = ss_addr - SS_BASE;
    assign ss_hit = (ss_off[7:2] == 6'd0);

    // Glitch filter, arming FSM, tick counter and save-state restore
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            a12_flt  <= 1'b1;
            gcnt     <= 4'd0;
            state    <= ST_HIGH;
            low_cnt  <= 3'd0;
            a12_rise <= 1'b0;
            tick_cnt <= 8'd0;
        end else if (ss_act) begin
            // Session active: everything holds except register restores
            a12_rise <= 1'b0;
            if (ss_we && ss_hit) begin
                case (ss_off[1:0])
                    SS_OFF_TICK: tick_cnt <= ss_din;
                    SS_OFF_STAT: begin
                        state   <= a12_state_t'(ss_din[7:6]);
                        a12_flt <= ss_din[5];
                        low_cnt <= ss_din[4:2];
                    end
                    SS_OFF_GCNT: gcnt <= ss_din[3:0];
                    default: ;
                endcase
            end
        end else begin
            a12_rise <= 1'b0;

            // A new A12 level must persist GLITCH_CLK samples before the filtered level follows
            if (a12_s == a12_flt) begin
                gcnt <= 4'd0;
            end else if (gcnt >= GLITCH_LAST) begin
                a12_flt <= ~a12_flt;
                gcnt    <= 4'd0;
            end else begin
                gcnt <= gcnt + 4'd1;
            end

            // The FSM reacts to the registered filtered level, one clk behind the filter
            case (state)
                ST_HIGH: begin
                    if (!a12_flt) begin
                        state   <= ST_LOW;
                        low_cnt <= 3'd0;
                    end
                end
                ST_LOW: begin
                    low_cnt <= low_next;
                    if (a12_flt) begin
                        state <= ST_HIGH;
                        if (low_next >= LOW_TGT && en) begin
                            a12_rise <= 1'b1;
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end else if (low_next >= LOW_TGT) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (a12_flt) begin
                        state <= ST_HIGH;
                        if (en) begin
                            a12_rise <= 1'b1;
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_HIGH;
            endcase
        end
    end

    assign armed = (state == ST_ARMED);

    // Save-state read mux; unowned addresses float high
    always_comb begin
        ss_rdat = 8'hFF;
        if (ss_hit) begin
            case (ss_off[1:0])
                SS_OFF_TICK: ss_rdat = tick_cnt;
                SS_OFF_STAT: ss_rdat = {state, a12_flt, low_cnt, 2'b00};
                SS_OFF_GCNT: ss_rdat = {4'b0000, gcnt};
                default:     ss_rdat = CFG_WORD;
            endcase
        end
    end

endmodule
